// File: rtl/serial_adder_dfa_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master issues operations, the slave (the adder) returns results.
interface serial_adder_dfa_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;

    modport master (
        output start, a, b, sub,
        input  busy, done, s, c, ovf
    );

    modport slave (
        input  start, a, b, sub,
        output busy, done, s, c, ovf
    );
endinterface

// File: rtl/serial_adder_dfa.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry DFA,
// LSB first, one bit per clock, result presented with a done pulse.
module serial_adder_dfa #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_adder_dfa_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] s_q;
    logic [CW-1:0]    cnt_q;
    logic             cy_q;
    logic             cmsb_q;
    logic             c_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             sum_bit;
    logic             cy_nxt;
    logic [WIDTH-1:0] w_nxt;

    // A request is only taken when no operation is in flight.
    assign accept = bus.start && (state == IDLE || state == DONE);

    // Full-adder cell on the current LSBs and the carry state.
    assign sum_bit = sa_q[0] ^ sb_q[0] ^ cy_q;
    assign cy_nxt  = (sa_q[0] & sb_q[0])
                   | (sa_q[0] & cy_q)
                   | (sb_q[0] & cy_q);
    assign w_nxt   = {sum_bit, w_q[WIDTH-1:1]};

    // Carry DFA, operand shifters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa_q   <= '0;
            sb_q   <= '0;
            w_q    <= '0;
            s_q    <= '0;
            cnt_q  <= '0;
            cy_q   <= 1'b0;
            cmsb_q <= 1'b0;
            c_q    <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                sa_q   <= bus.a;
                sb_q   <= bus.sub ? ~bus.b : bus.b;
                cy_q   <= bus.sub;
                cnt_q  <= '0;
                busy_q <= 1'b1;
                state  <= RUN;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        sa_q  <= sa_q >> 1;
                        sb_q  <= sb_q >> 1;
                        w_q   <= w_nxt;
                        cy_q  <= cy_nxt;
                        cnt_q <= cnt_q + CW'(1);
                        // Carry leaving bit WIDTH-2 is the carry into the MSB.
                        if (cnt_q == PRE) begin
                            cmsb_q <= cy_nxt;
                        end
                        if (cnt_q == LAST) begin
                            s_q    <= w_nxt;
                            c_q    <= cy_nxt;
                            ovf_q  <= cmsb_q ^ cy_nxt;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.c    = c_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_dfa.sv
// Bench for serial_adder_dfa at WIDTH 8, 16 and 2: directed scenarios
// plus random operations against an arithmetic reference model.
module tb_serial_adder_dfa;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_adder_dfa_if #(.WIDTH(8))  if8 ();
    serial_adder_dfa_if #(.WIDTH(16)) if16 ();
    serial_adder_dfa_if #(.WIDTH(2))  if2 ();

    serial_adder_dfa #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8)
    );
    serial_adder_dfa #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16)
    );
    serial_adder_dfa #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );

    // Free-running clock, 10 time units period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain modular and signed integer arithmetic.
    function automatic void model(input int w, input longint a,
                                  input longint b, input bit sub,
                                  output longint s, output bit c,
                                  output bit o);
        longint m;
        longint r;
        longint xa;
        longint xb;
        longint sr;
        m = longint'(1) << w;
        if (sub) begin
            r = a - b;
            c = (a >= b);
            if (r < 0) r = r + m;
        end else begin
            r = a + b;
            c = (r >= m);
        end
        s  = r % m;
        xa = (a >= m / 2) ? a - m : a;
        xb = (b >= m / 2) ? b - m : b;
        sr = sub ? xa - xb : xa + xb;
        o  = (sr < -(m / 2)) || (sr >= m / 2);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input bit sub, output logic [7:0] s,
                        output bit c, output bit o, output int lat,
                        output int bn, output bit ok);
        if8.start = 1'b1;
        if8.a = a;
        if8.b = b;
        if8.sub = sub;
        @(negedge clk);
        if8.start = 1'b0;
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        if8.sub = 1'($urandom);
        lat = 0;
        bn = 0;
        while (if8.done !== 1'b1 && lat < 100) begin
            if (if8.busy === 1'b1) bn++;
            @(negedge clk);
            lat++;
        end
        ok = (if8.done === 1'b1);
        s = if8.s;
        c = if8.c;
        o = if8.ovf;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input bit sub, output logic [15:0] s,
                         output bit c, output bit o, output int lat,
                         output bit ok);
        if16.start = 1'b1;
        if16.a = a;
        if16.b = b;
        if16.sub = sub;
        @(negedge clk);
        if16.start = 1'b0;
        if16.a = 16'($urandom);
        if16.b = 16'($urandom);
        lat = 0;
        while (if16.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ok = (if16.done === 1'b1);
        s = if16.s;
        c = if16.c;
        o = if16.ovf;
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b,
                        input bit sub, output logic [1:0] s,
                        output bit c, output bit o, output int lat,
                        output bit ok);
        if2.start = 1'b1;
        if2.a = a;
        if2.b = b;
        if2.sub = sub;
        @(negedge clk);
        if2.start = 1'b0;
        if2.a = 2'($urandom);
        if2.b = 2'($urandom);
        lat = 0;
        while (if2.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ok = (if2.done === 1'b1);
        s = if2.s;
        c = if2.c;
        o = if2.ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({if8.busy, if8.done, if8.s, if8.c, if8.ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b s=%h c=%b ovf=%b want all 0",
                     if8.busy, if8.done, if8.s, if8.c, if8.ovf);
        end
        checks++;
        if ({if16.busy, if16.done, if16.s, if16.c, if16.ovf} !== 20'h0) begin
            errors++;
            $display("FAIL reset16 got s=%h busy=%b done=%b want all 0",
                     if16.s, if16.busy, if16.done);
        end
        checks++;
        if ({if2.busy, if2.done, if2.s, if2.c, if2.ovf} !== 6'h0) begin
            errors++;
            $display("FAIL reset2 got s=%b busy=%b done=%b want all 0",
                     if2.s, if2.busy, if2.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_wrap8();
        logic [7:0] s;
        bit c, o, ok;
        int lat, bn;
        run8(8'hFF, 8'h01, 1'b0, s, c, o, lat, bn, ok);
        checks++;
        if (!ok || s !== 8'h00 || c !== 1'b1 || o !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap8 got ok=%0d s=%h c=%b ovf=%b want s=00 c=1 ovf=0",
                     ok, s, c, o);
        end
        checks++;
        if (lat != 8 || bn != 8) begin
            errors++;
            $display("FAIL latency8 got lat=%0d busy_cycles=%0d want 8 and 8", lat, bn);
        end
        checks++;
        if (if8.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done got %b want 0", if8.busy);
        end
        @(negedge clk);
        checks++;
        if (if8.done !== 1'b0) begin
            errors++;
            $display("FAIL done_width got done=%b one cycle later want 0", if8.done);
        end
    endtask

    task automatic test_overflow8();
        logic [7:0] s;
        bit c, o, ok;
        int lat, bn;
        run8(8'h7F, 8'h01, 1'b0, s, c, o, lat, bn, ok);
        checks++;
        if (!ok || s !== 8'h80 || c !== 1'b0 || o !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf8 got s=%h c=%b ovf=%b want s=80 c=0 ovf=1", s, c, o);
        end
        run8(8'h80, 8'h01, 1'b1, s, c, o, lat, bn, ok);
        checks++;
        if (!ok || s !== 8'h7F || c !== 1'b1 || o !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf8 got s=%h c=%b ovf=%b want s=7f c=1 ovf=1", s, c, o);
        end
    endtask

    task automatic test_sub8();
        logic [7:0] s;
        bit c, o, ok;
        int lat, bn;
        run8(8'h05, 8'h07, 1'b1, s, c, o, lat, bn, ok);
        checks++;
        if (!ok || s !== 8'hFE || c !== 1'b0 || o !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow8 got s=%h c=%b ovf=%b want s=fe c=0 ovf=0", s, c, o);
        end
        run8(8'h07, 8'h07, 1'b1, s, c, o, lat, bn, ok);
        checks++;
        if (!ok || s !== 8'h00 || c !== 1'b1 || o !== 1'b0) begin
            errors++;
            $display("FAIL sub_equal8 got s=%h c=%b ovf=%b want s=00 c=1 ovf=0", s, c, o);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        if8.start = 1'b1;
        if8.a = 8'h10;
        if8.b = 8'h20;
        if8.sub = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = 8'hFF;
        if8.b = 8'hFF;
        checks++;
        if (if8.s !== 8'h00 || if8.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_in_run got s=%h busy=%b want s=00 busy=1",
                     if8.s, if8.busy);
        end
        @(negedge clk);
        if8.start = 1'b0;
        lat = 3;
        while (if8.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (if8.done !== 1'b1 || lat != 8 || if8.s !== 8'h30 || if8.c !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d s=%h c=%b want lat=8 s=30 c=0",
                     lat, if8.s, if8.c);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.done === 1'b1 || if8.busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL no_second_op got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        logic [7:0] s1;
        if8.start = 1'b1;
        if8.a = 8'h03;
        if8.b = 8'h04;
        if8.sub = 1'b0;
        lat = 0;
        @(negedge clk);
        while (if8.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        s1 = if8.s;
        if8.a = 8'h01;
        if8.b = 8'h01;
        @(negedge clk);
        gap = 1;
        checks++;
        if (if8.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b after done cycle want 1", if8.busy);
        end
        if8.start = 1'b0;
        while (if8.done !== 1'b1 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (s1 !== 8'h07 || gap != 9 || if8.s !== 8'h02) begin
            errors++;
            $display("FAIL back_to_back got first=%h gap=%0d second=%h want 07 9 02",
                     s1, gap, if8.s);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        bit c, o, ok;
        int lat, bn, seen;
        if8.start = 1'b1;
        if8.a = 8'hAA;
        if8.b = 8'h55;
        if8.sub = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.s, if8.c, if8.ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b s=%h c=%b ovf=%b want all 0",
                     if8.busy, if8.done, if8.s, if8.c, if8.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.done === 1'b1 || if8.busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d active cycles want 0", seen);
        end
        run8(8'h01, 8'h02, 1'b0, s, c, o, lat, bn, ok);
        checks++;
        if (!ok || s !== 8'h03 || c !== 1'b0 || o !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got s=%h c=%b ovf=%b want s=03 c=0 ovf=0", s, c, o);
        end
    endtask

    task automatic test_width16();
        logic [15:0] s;
        bit c, o, ok;
        int lat;
        run16(16'hFFFF, 16'h0001, 1'b0, s, c, o, lat, ok);
        checks++;
        if (!ok || lat != 16 || s !== 16'h0000 || c !== 1'b1 || o !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap16 got lat=%0d s=%h c=%b ovf=%b want 16 0000 1 0",
                     lat, s, c, o);
        end
        run16(16'h0005, 16'h0007, 1'b1, s, c, o, lat, ok);
        checks++;
        if (!ok || s !== 16'hFFFE || c !== 1'b0 || o !== 1'b0) begin
            errors++;
            $display("FAIL sub16 got s=%h c=%b ovf=%b want fffe 0 0", s, c, o);
        end
    endtask

    task automatic test_width2();
        logic [1:0] s;
        bit c, o, ok;
        int lat;
        run2(2'b00, 2'b01, 1'b1, s, c, o, lat, ok);
        checks++;
        if (!ok || lat != 2 || s !== 2'b11 || c !== 1'b0 || o !== 1'b0) begin
            errors++;
            $display("FAIL sub2 got lat=%0d s=%b c=%b ovf=%b want 2 11 0 0",
                     lat, s, c, o);
        end
        run2(2'b11, 2'b01, 1'b0, s, c, o, lat, ok);
        checks++;
        if (!ok || s !== 2'b00 || c !== 1'b1 || o !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap2 got s=%b c=%b ovf=%b want 00 1 0", s, c, o);
        end
    endtask

    task automatic test_random();
        longint ra, rb, es;
        bit rsub, ec, eo, c, o, ok;
        int lat, bn;
        logic [7:0] s8;
        logic [15:0] s16;
        logic [1:0] s2;
        for (int i = 0; i < 40; i++) begin
            ra = longint'($urandom_range(0, 255));
            rb = longint'($urandom_range(0, 255));
            rsub = 1'($urandom);
            model(8, ra, rb, rsub, es, ec, eo);
            run8(8'(ra), 8'(rb), rsub, s8, c, o, lat, bn, ok);
            checks++;
            if (!ok || s8 !== 8'(es) || c !== ec || o !== eo) begin
                errors++;
                $display("FAIL rand8 a=%h b=%h sub=%0d got s=%h c=%b ovf=%b want s=%h c=%b ovf=%b",
                         ra, rb, rsub, s8, c, o, 8'(es), ec, eo);
            end
        end
        for (int i = 0; i < 20; i++) begin
            ra = longint'($urandom_range(0, 65535));
            rb = longint'($urandom_range(0, 65535));
            rsub = 1'($urandom);
            model(16, ra, rb, rsub, es, ec, eo);
            run16(16'(ra), 16'(rb), rsub, s16, c, o, lat, ok);
            checks++;
            if (!ok || s16 !== 16'(es) || c !== ec || o !== eo) begin
                errors++;
                $display("FAIL rand16 a=%h b=%h sub=%0d got s=%h c=%b ovf=%b want s=%h c=%b ovf=%b",
                         ra, rb, rsub, s16, c, o, 16'(es), ec, eo);
            end
        end
        for (int i = 0; i < 20; i++) begin
            ra = longint'($urandom_range(0, 3));
            rb = longint'($urandom_range(0, 3));
            rsub = 1'($urandom);
            model(2, ra, rb, rsub, es, ec, eo);
            run2(2'(ra), 2'(rb), rsub, s2, c, o, lat, ok);
            checks++;
            if (!ok || s2 !== 2'(es) || c !== ec || o !== eo) begin
                errors++;
                $display("FAIL rand2 a=%0d b=%0d sub=%0d got s=%b c=%b ovf=%b want s=%b c=%b ovf=%b",
                         ra, rb, rsub, s2, c, o, 2'(es), ec, eo);
            end
        end
    endtask

    // Scenario sequence; each task leaves the bench on a falling edge.
    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b1;
        if8.start = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if8.sub = 1'b0;
        if16.start = 1'b0;
        if16.a = '0;
        if16.b = '0;
        if16.sub = 1'b0;
        if2.start = 1'b0;
        if2.a = '0;
        if2.b = '0;
        if2.sub = 1'b0;
        test_reset();
        test_add_wrap8();
        test_overflow8();
        test_sub8();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_width16();
        test_width2();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
